alu_operand_seq: RTL and testbench

//  Operand/accumulator stage wrapped around the CPU's registered 8-bit add/sub ALU.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/alu_operand_seq.sv | 87 ++++++++
 tb/tb_alu_operand_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: FSM state encoding, ALU op codes and the default datapath width.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_operand_seq.sv
// Accumulator/operand stage around the registered add/sub ALU: holds A and B, runs
// one ALU cycle per start, writes the registered result back into A and raises flags.
module alu_operand_seq
    import cpu_pkg::*;
#(
    parameter int              DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] ACC_RST = '0,
    parameter int              CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              start,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] opA,
    output logic [DATA_W-1:0] opB,
    output logic              sel,
    output logic [DATA_W-1:0] acc_out,
    output logic              busy,
    output logic              done,
    output logic              flag_z,
    output logic              flag_n,
    output logic [CNT_W-1:0]  op_cnt
);

    logic [1:0]        state;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic              sel_q;
    logic              done_q;
    logic              z_q;
    logic              n_q;
    logic [CNT_W-1:0]  cnt_q;

    // The unreachable encoding 2'd3 falls into the default arm and behaves as IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            reg_a  <= ACC_RST;
            reg_b  <= ACC_RST;
            sel_q  <= OP_ADD;
            done_q <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_EXEC: begin
                    state <= ST_WB;
                end
                ST_WB: begin
                    reg_a  <= alu_res;
                    z_q    <= (alu_res == '0);
                    n_q    <= alu_res[DATA_W-1];
                    cnt_q  <= cnt_q + CNT_W'(1);
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    if (load_a) reg_a <= bus_in;
                    if (load_b) reg_b <= bus_in;
                    if (start) begin
                        sel_q <= op_sub;
                        state <= ST_EXEC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign opA     = reg_a;
    assign opB     = reg_b;
    assign sel     = sel_q;
    assign acc_out = reg_a;
    assign busy    = (state == ST_EXEC) || (state == ST_WB);
    assign done    = done_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;
    assign op_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq with a behavioural registered add/sub ALU and a 10 ns clock.
module tb_alu_operand_seq;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic       load_a;
    logic       load_b;
    logic       start;
    logic       op_sub;
    logic [7:0] alu_res;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       sel;
    logic [7:0] acc_out;
    logic       busy;
    logic       done;
    logic       flag_z;
    logic       flag_n;
    logic [7:0] op_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    // Stand-in for the CPU's registered ALU: captures operands on every edge.
    always_ff @(posedge clk) begin
        alu_res <= sel ? (opA - opB) : (opA + opB);
    end

    alu_operand_seq dut (
        .clk     (clk),
        .rst     (rst),
        .bus_in  (bus_in),
        .load_a  (load_a),
        .load_b  (load_b),
        .start   (start),
        .op_sub  (op_sub),
        .alu_res (alu_res),
        .opA     (opA),
        .opB     (opB),
        .sel     (sel),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .op_cnt  (op_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        load_a = 1'b0;
        load_b = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        bus_in = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Loads A, then loads B in the same cycle as start, then walks EXEC and WB.
    task automatic applyStimulus(input vec_t v);
        bus_in = v.a;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        bus_in = v.b;
        load_b = 1'b1;
        start  = 1'b1;
        op_sub = v.sub;
        tick();
        idle_inputs();
        checkOutput("exec_busy", 32'(busy), 32'd1);
        checkOutput("exec_done", 32'(done), 32'd0);
        checkOutput("exec_opA", 32'(opA), 32'(v.a));
        checkOutput("exec_opB", 32'(opB), 32'(v.b));
        checkOutput("exec_sel", 32'(sel), 32'(v.sub));
        tick();
        checkOutput("wb_done", 32'(done), 32'd0);
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("acc_out", 32'(acc_out), 32'(v.res));
        checkOutput("flag_z", 32'(flag_z), 32'(v.z));
        checkOutput("flag_n", 32'(flag_n), 32'(v.n));
        checkOutput("op_cnt", 32'(op_cnt), 32'(exp_cnt));
        tick();
        checkOutput("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        logic       drive_start;
        logic [7:0] exp_acc;
        int         done_seen;

        vecs[0] = '{a: 8'h05, b: 8'h03, sub: OP_ADD, res: 8'h08, z: 1'b0, n: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, sub: OP_SUB, res: 8'hFE, z: 1'b0, n: 1'b1};
        vecs[2] = '{a: 8'hFE, b: 8'hFE, sub: OP_SUB, res: 8'h00, z: 1'b1, n: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'h01, sub: OP_ADD, res: 8'h00, z: 1'b1, n: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, sub: OP_SUB, res: 8'h7F, z: 1'b0, n: 1'b0};
        vecs[5] = '{a: 8'h7F, b: 8'h01, sub: OP_ADD, res: 8'h80, z: 1'b0, n: 1'b1};
        vecs[6] = '{a: 8'h00, b: 8'h01, sub: OP_SUB, res: 8'hFF, z: 1'b0, n: 1'b1};
        vecs[7] = '{a: 8'h10, b: 8'h20, sub: OP_ADD, res: 8'h30, z: 1'b0, n: 1'b0};

        do_reset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_acc", 32'(acc_out), 32'd0);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_cnt", 32'(op_cnt), 32'd0);
        checkOutput("rst_z", 32'(flag_z), 32'd0);
        checkOutput("rst_n", 32'(flag_n), 32'd0);

        // Reset in the middle of EXEC: no write-back, no done pulse.
        bus_in = 8'h11; load_a = 1'b1; load_b = 1'b1; start = 1'b1;
        tick();
        idle_inputs();
        checkOutput("midop_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_acc", 32'(acc_out), 32'd0);
        checkOutput("abort_cnt", 32'(op_cnt), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_done", 32'(done), 32'd0);
            checkOutput("abort_acc_hold", 32'(acc_out), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back ops, start raised only in the done cycle; a load during EXEC is ignored.
        do_reset();
        bus_in = 8'h01; load_a = 1'b1; tick();
        bus_in = 8'h02; load_a = 1'b0; load_b = 1'b1; tick();
        idle_inputs();
        exp_acc     = 8'h01;
        done_seen   = 0;
        drive_start = 1'b1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            start  = drive_start;
            load_a = (cyc % 3 == 2);
            bus_in = 8'h77;
            tick();
            checkOutput("b2b_done", 32'(done), 32'((cyc % 3) == 0));
            if (cyc % 3 == 0) begin
                exp_acc = exp_acc + 8'h02;
                checkOutput("b2b_acc", 32'(acc_out), 32'(exp_acc));
            end
            if (done) done_seen++;
            drive_start = done && (cyc < 9);
        end
        idle_inputs();
        checkOutput("b2b_pulses", 32'(done_seen), 32'd3);
        checkOutput("b2b_cnt", 32'(op_cnt), 32'd3);

        // 256 increments wrap both the counter and the accumulator to zero.
        do_reset();
        bus_in = 8'h01; load_b = 1'b1; tick();
        idle_inputs();
        for (int k = 1; k <= 256; k++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            if (k == 255) begin
                checkOutput("cnt_255", 32'(op_cnt), 32'hFF);
                checkOutput("acc_255", 32'(acc_out), 32'hFF);
                checkOutput("n_255", 32'(flag_n), 32'd1);
            end
        end
        checkOutput("cnt_wrap", 32'(op_cnt), 32'h00);
        checkOutput("acc_wrap", 32'(acc_out), 32'h00);
        checkOutput("z_wrap", 32'(flag_z), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
